div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Multi-cycle controller for MIPS DIV/DIVU in the execute stage.
- Sequences a radix-2 restoring division over WIDTH iterations.
- Raises the div_stall request that the hazard unit turns into stallF/stallD/stallE.
- Delivers a one-cycle {hi, lo} result for the HI/LO register write.

Parameters:
- WIDTH, 32, operand and result width in bits. The iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  E-stage instruction is DIV/DIVU; sampled in IDLE only.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- annul  input  1  E-stage flush; aborts any in-flight division.
- dividend  input  WIDTH  rs operand (forwarded srca2E).
- divisor  input  WIDTH  rt operand (forwarded srcb3E).
- div_stall  output  1  pipeline hold request.
- ready  output  1  single-cycle result-valid strobe.
- hi  output  WIDTH  remainder, valid while ready=1.
- lo  output  WIDTH  quotient, valid while ready=1.

Behaviour:
- Reset values (async, immediate): state=IDLE, counter=0, ready=0, hi=0, lo=0, div_stall=0, internal registers cleared.
- States are IDLE, CALC and DONE.
- IDLE:
  - div_stall = start & ~annul, combinational, so the start cycle itself already stalls.
  - On an edge with start=1 and annul=0, latch the operands:
    - signed_div=1: latch |dividend| and |divisor|; record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
    - signed_div=0: latch the raw values; neg_q = neg_r = 0.
  - Clear counter; go to CALC.
- CALC:
  - div_stall=1.
  - Each cycle: shift the {rem, quo} pair left by 1; trial-subtract the divisor from rem (WIDTH+1-bit subtract).
  - If the result is non-negative, keep it and set quo[0]=1; otherwise restore and set quo[0]=0.
  - counter increments each cycle; after WIDTH iterations go to DONE.
- DONE:
  - div_stall=0, ready=1.
  - lo = neg_q ? -quo : quo; hi = neg_r ? -rem : rem (two's complement, truncated to WIDTH).
  - start is ignored here: the stalled instruction is still in E this cycle.
  - Next state is IDLE unconditionally.
- Latency: start accepted in cycle 0, CALC occupies cycles 1..WIDTH, DONE is cycle WIDTH+1.
  - div_stall is high for exactly WIDTH+1 cycles.
  - ready is high for exactly 1 cycle.
- hi/lo hold their last DONE value outside DONE; consumers must qualify with ready.
- annul:
  - In any state, annul=1 forces div_stall=0 combinationally.
  - The next edge goes to IDLE with ready=0; the partial result is discarded.
  - annul takes priority over start in the same cycle.
- Overflow case, 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0; no trap.
- Divide by zero (optional feature off): runs the full sequence. Natural result is quo = all ones and rem = dividend magnitude, with sign fixup applied.
- Reset asserted mid-CALC: immediate return to IDLE with all outputs at reset values; no ready pulse.
- Back-to-back divides: the second start is accepted in the IDLE cycle following DONE. No bubble is required beyond that cycle.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- When defined:
  - Adds output port div_zero (1 bit, reset 0).
  - An IDLE accept with divisor==0 goes straight to DONE (latency 1, div_stall high for 1 cycle).
  - DONE outputs lo=all ones, hi=dividend (raw, no sign fixup) and div_zero=1; div_zero is 0 at all other times.
- When undefined: no div_zero port; divide by zero takes the full WIDTH+1-cycle path as described above.

Test Plan:
- DIVU 7 / 2 -> div_stall high for 33 cycles, then ready=1 with lo=0x00000003, hi=0x00000001.
- DIV -7 / 2 (0xFFFFFFF9, 0x00000002) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000; no hang.
- annul asserted at CALC iteration 10 -> div_stall drops the same cycle, IDLE next edge, no ready pulse. A new DIVU 100/7 started after that -> lo=14, hi=2.
- rst pulsed asynchronously mid-CALC -> outputs zero immediately. Two back-to-back DIVU ops (9/3, then 10/4) -> ready pulses 34 cycles apart with results 3/0 and 2/2.
- Divisor 0, dividend 0x12345678, DIVU:
  - With DIV_ZERO_FAST_EN: ready at cycle 1, lo=0xFFFFFFFF, hi=0x12345678, div_zero=1.
  - Without it: same values after 33 stall cycles.

Source files
------------

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider controller for MIPS DIV/DIVU in the E stage.
// Optional DIV_ZERO_FAST_EN: adds div_zero and a one-cycle divide-by-zero path.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef DIV_ZERO_FAST_EN
  ,
  output logic             div_zero
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic             neg_q, neg_r;

  logic             accept;
  logic             last_iter;
  logic             zero_fast;
  logic [WIDTH-1:0] abs_dividend, abs_divisor;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_step, quo_step;

  assign accept    = (state == IDLE) && start && !annul;
  assign last_iter = (state == CALC) && (count == CW'(WIDTH - 1));

`ifdef DIV_ZERO_FAST_EN
  assign zero_fast = (divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  assign abs_dividend = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_divisor  = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;

  // rem < dvsr keeps rem_sh below 2*dvsr, so bit WIDTH of the difference is its sign
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, dvsr};
  assign trial_ok = ~diff[WIDTH];
  assign rem_step = trial_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], trial_ok};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and the combinational stall request
  always_comb begin
    state_nxt = state;
    div_stall = 1'b0;
    case (state)
      IDLE: begin
        div_stall = start;
        if (start) state_nxt = zero_fast ? DONE : CALC;
      end
      CALC: begin
        div_stall = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul) begin
      div_stall = 1'b0;
      state_nxt = IDLE;
    end
  end

  // Datapath: operand capture, iteration, and sign-fixed result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ready <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef DIV_ZERO_FAST_EN
      div_zero <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
      div_zero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            count <= '0;
            rem   <= '0;
            quo   <= abs_dividend;
            dvsr  <= abs_divisor;
            neg_q <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= signed_div & dividend[WIDTH-1];
            if (zero_fast) begin
              ready <= 1'b1;
              lo    <= '1;
              hi    <= dividend;
`ifdef DIV_ZERO_FAST_EN
              div_zero <= 1'b1;
`endif
            end
          end
        end
        CALC: begin
          if (!annul) begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + CW'(1);
            if (last_iter) begin
              ready <= 1'b1;
              lo    <= neg_q ? -quo_step : quo_step;
              hi    <= neg_r ? -rem_step : rem_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: scoreboard of expected {hi, lo} per accepted divide.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        div_stall;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef DIV_ZERO_FAST_EN
  logic        div_zero;
`endif

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          last_ready_cyc = 0;
  logic [63:0] exp_q[$];

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
    .dividend(dividend), .divisor(divisor), .div_stall(div_stall), .ready(ready),
    .hi(hi), .lo(lo)
`ifdef DIV_ZERO_FAST_EN
    , .div_zero(div_zero)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference divide: 64-bit signed arithmetic avoids the overflow corner
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    longint sa, sb;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
      q = '1; r = a;
`else
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
`endif
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int exp_stall, input string name);
    logic [63:0] e;
    int stalls;
    bit got;
    exp_q.push_back(model(s, a, b));
    @(negedge clk);
    start = 1'b1; signed_div = s; dividend = a; divisor = b;
    stalls = 0; got = 0;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (div_stall) stalls++;
      if (ready) begin got = 1; break; end
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    n_total++;
    if (!got) begin
      $display("FAIL %s timeout: ready never seen, stall cycles %0d", name, stalls);
      return;
    end else n_pass++;
    last_ready_cyc = cyc;
    n_total++;
    if (stalls !== exp_stall)
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stall);
    else n_pass++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    n_total++;
    if ({hi, lo} !== e)
      $display("FAIL %s result: hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, e[63:32], e[31:0]);
    else n_pass++;
`ifdef DIV_ZERO_FAST_EN
    n_total++;
    if (div_zero !== (b == 32'd0))
      $display("FAIL %s div_zero: got %b expected %b", name, div_zero, (b == 32'd0));
    else n_pass++;
`endif
  endtask

  task automatic watch_no_ready(input int cycles, input string name);
    int pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk); #1;
      if (ready) pulses++;
    end
    n_total++;
    if (pulses !== 0) $display("FAIL %s spurious_ready: got %0d pulses expected 0", name, pulses);
    else n_pass++;
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if ({ready, div_stall, hi, lo} !== 66'd0)
      $display("FAIL reset_values: ready=%b stall=%b hi=%h lo=%h expected all 0", ready, div_stall, hi, lo);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_divu();
    logic [31:0] h0, l0;
    do_div(1'b0, 32'd7, 32'd2, 33, "divu_7_2");
    n_total++;
    if (lo !== 32'd3 || hi !== 32'd1) $display("FAIL divu_7_2_const: hi=%h lo=%h expected 1/3", hi, lo);
    else n_pass++;
    h0 = hi; l0 = lo;
    @(negedge clk); #1;
    n_total++;
    if (ready !== 1'b0 || hi !== h0 || lo !== l0)
      $display("FAIL ready_single_hold: ready=%b hi=%h lo=%h expected 0/%h/%h", ready, hi, lo, h0, l0);
    else n_pass++;
  endtask

  task automatic test_signed();
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, "div_m7_2");
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div_overflow");
    do_div(1'b1, 32'd100, 32'hFFFF_FFF9, 33, "div_100_m7");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == 32'd0) b = 32'd1;
      do_div(i[0], a, b, 33, "random");
    end
  endtask

  task automatic test_annul();
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    n_total++;
    if (div_stall !== 1'b1) $display("FAIL annul_pre_stall: got %b expected 1", div_stall);
    else n_pass++;
    annul = 1'b1; #1;
    n_total++;
    if (div_stall !== 1'b0) $display("FAIL annul_stall_drop: got %b expected 0", div_stall);
    else n_pass++;
    @(negedge clk); annul = 1'b0; #1;
    n_total++;
    if (ready !== 1'b0 || div_stall !== 1'b0)
      $display("FAIL annul_idle: ready=%b stall=%b expected 0/0", ready, div_stall);
    else n_pass++;
    watch_no_ready(40, "annul");
    do_div(1'b0, 32'd100, 32'd7, 33, "divu_100_7");
  endtask

  task automatic test_reset_mid_calc();
    int r1;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; dividend = 32'hFFFF_FFFF; divisor = 32'd5;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1; #1;
    n_total++;
    if ({ready, div_stall, hi, lo} !== 66'd0)
      $display("FAIL reset_mid_calc: ready=%b stall=%b hi=%h lo=%h expected all 0", ready, div_stall, hi, lo);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    watch_no_ready(40, "reset_mid_calc");
    do_div(1'b0, 32'd9, 32'd3, 33, "b2b_9_3");
    r1 = last_ready_cyc;
    do_div(1'b0, 32'd10, 32'd4, 33, "b2b_10_4");
    n_total++;
    if (last_ready_cyc - r1 !== 34)
      $display("FAIL back_to_back_spacing: got %0d cycles expected 34", last_ready_cyc - r1);
    else n_pass++;
  endtask

  task automatic test_div_zero();
`ifdef DIV_ZERO_FAST_EN
    do_div(1'b0, 32'h1234_5678, 32'd0, 1, "div_zero_fast");
`else
    do_div(1'b0, 32'h1234_5678, 32'd0, 33, "div_zero_full");
`endif
    n_total++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678)
      $display("FAIL div_zero_const: hi=%h lo=%h expected 12345678/ffffffff", hi, lo);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_random();
    test_annul();
    test_reset_mid_calc();
    test_div_zero();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
